neuron_mac_accumulator: RTL and testbench
=========================================

Name: neuron_mac_accumulator

Overview:
- Streaming dot-product stage that sits directly upstream of the CORDIC sigmoid/tanh activation block.
- Accepts VEC_LEN (activation, weight) pairs over a valid/ready handshake and accumulates their products at full width.
- Adds a per-vector bias, rescales back to Q4.12, saturates to 16 bits and presents one result per vector on a valid/ready output that feeds the activation input x.

Parameters:
- DATA_W, 16: width of activations, weights, bias and result (signed Q4.12).
- FRAC_W, 12: fractional bits of the data format.
- VEC_LEN, 8: beats per vector, legal range 2..256.
- ACC_W, 40: accumulator width; must satisfy ACC_W >= 2*DATA_W + clog2(VEC_LEN) + 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat.
- in_data  in  DATA_W  signed activation.
- in_weight  in  DATA_W  signed weight.
- in_last  in  1  producer's end-of-vector marker; used for checking only.
- bias  in  DATA_W  signed bias, sampled on the first beat of each vector.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_W  saturated signed Q4.12 result.
- out_sat  out  1  result was clipped.
- len_err  out  1  in_last did not match the VEC_LEN framing for this vector.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (rst_n).
- Reset values (while rst_n=0):
  - state=ACCUM, acc=0, cnt=0, bias_q=0.
  - out_valid=0, out_data=0, out_sat=0, len_err=0, err_q=0.
  - in_ready=0.
  - Reset asserted mid-vector or during OUT discards all partial or pending work; no output is produced for that vector.
- States: ACCUM, FINAL, OUT.
- ACCUM:
  - in_ready=1.
  - Accepted beat (in_valid & in_ready): acc += sign-extended full-width product in_data*in_weight; cnt++.
  - On cnt==0, bias is captured into bias_q.
  - err_q is set if in_last=1 on a beat where cnt != VEC_LEN-1, or if in_last=0 on the beat where cnt == VEC_LEN-1.
  - The vector always ends after exactly VEC_LEN beats, regardless of in_last. After the final beat, go to FINAL.
- FINAL (one cycle, in_ready=0):
  - s = acc + (sext(bias_q) << FRAC_W).
  - r = s >>> FRAC_W (arithmetic shift; see Optional Feature for rounding).
  - Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Register out_data; out_sat = clipped; len_err = err_q; out_valid <= 1. Go to OUT.
- OUT:
  - in_ready=0.
  - out_valid, out_data, out_sat and len_err are held stable until out_ready=1.
  - On the cycle with out_valid & out_ready: next out_valid=0, acc=0, cnt=0, err_q=0; go to ACCUM. in_ready is 1 on the following cycle.
- Latency:
  - Last beat accepted in cycle T → out_valid=1 in cycle T+2.
  - Minimum vector period is VEC_LEN+2 cycles when out_ready is held at 1.
- Boundary rules:
  - Beats offered while in_ready=0 are not consumed.
  - out_ready while out_valid=0 is ignored.
  - Accumulator never wraps, because of the ACC_W constraint.
  - Saturation is applied only at output conversion.

Optional Feature:
- Macro: NEURON_MAC_ROUND_EN.
- Defined: in FINAL, add 2^(FRAC_W-1) to s before the arithmetic shift (round half up).
- Undefined: plain arithmetic shift (truncation toward -infinity).
- Saturation, out_sat and timing are identical in both builds.

Test Plan:
- Nominal: VEC_LEN=4, four beats of (0x1000, 0x1000), bias=0, out_ready=1 → out_data=0x4000, out_sat=0, len_err=0, out_valid exactly 2 cycles after the last beat.
- Bias: four beats of (0x0800, 0x1000), bias=0xF000 → out_data=0x1000.
- Saturation:
  - Four beats of (0x7FFF, 0x7FFF) → out_data=0x7FFF, out_sat=1.
  - Four beats of (0x8000, 0x7FFF) → out_data=0x8000, out_sat=1.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 → out_valid and out_data stable, in_ready=0, no beats consumed; release → result accepted, next vector's first beat accepted the following cycle.
- Framing and reset:
  - in_last on beat 2 of 4 → result still covers 4 beats, len_err=1.
  - Next correctly framed vector → len_err=0.
  - rst_n=0 after 2 beats → all outputs 0; the following full vector yields the clean nominal result.
- Rounding: VEC_LEN=2, beats (0x0001, 0x0800), (0, 0), bias=0:
  - With NEURON_MAC_ROUND_EN → 0x0001; without → 0x0000.
  - Beats (0xFFFF, 0x0800), (0, 0): with the macro → 0x0000; without → 0xFFFF.

Source files
------------

// File: rtl/neuron_mac_accumulator_if.sv
// neuron_mac_accumulator_if: beat input and result output handshakes of the MAC stage.
interface neuron_mac_accumulator_if #(parameter int DATA_W = 16);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [DATA_W-1:0] in_weight;
   logic              in_last;
   logic [DATA_W-1:0] bias;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_sat;
   logic              len_err;
   modport master (
      output in_valid, in_data, in_weight, in_last, bias, out_ready,
      input  in_ready, out_valid, out_data, out_sat, len_err
   );
   modport slave (
      input  in_valid, in_data, in_weight, in_last, bias, out_ready,
      output in_ready, out_valid, out_data, out_sat, len_err
   );
endinterface

// File: rtl/neuron_mac_accumulator.sv
// neuron_mac_accumulator: VEC_LEN-beat dot product plus bias, rescaled and saturated to Q4.12.
// Defining NEURON_MAC_ROUND_EN rounds half up instead of truncating on the rescale.
module neuron_mac_accumulator #(
   parameter int DATA_W  = 16,
   parameter int FRAC_W  = 12,
   parameter int VEC_LEN = 8,
   parameter int ACC_W   = 40
) (
   input logic                    clk,
   input logic                    rst_n,
   neuron_mac_accumulator_if.slave bus
);
   localparam int CNT_W = $clog2(VEC_LEN);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);
   localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;
`ifdef NEURON_MAC_ROUND_EN
   localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (FRAC_W - 1);
`else
   localparam logic signed [ACC_W-1:0] RND = '0;
`endif
   typedef enum logic [1:0] {ACCUM, FINAL, OUT} state_t;
   state_t                    state, state_nx;
   logic signed [2*DATA_W-1:0] mul;
   logic signed [ACC_W-1:0]   acc, prod, s, r;
   logic [CNT_W-1:0]          cnt;
   logic [DATA_W-1:0]         bias_q;
   logic                      err_q, take, at_last, hi, lo;
   assign mul     = $signed(bus.in_data) * $signed(bus.in_weight);
   assign prod    = {{(ACC_W-2*DATA_W){mul[2*DATA_W-1]}}, mul};
   assign at_last = cnt == LAST;
   // Bias is aligned to the product's 2*FRAC_W binary point before the rescale.
   assign s       = acc + ({{(ACC_W-DATA_W){bias_q[DATA_W-1]}}, bias_q} << FRAC_W) + RND;
   assign r       = s >>> FRAC_W;
   assign hi      = r > SMAX;
   assign lo      = r < SMIN;
   always_comb begin
      bus.in_ready = rst_n && state == ACCUM;
      take         = bus.in_valid && bus.in_ready;
      state_nx     = state == ACCUM ? (take && at_last ? FINAL : ACCUM) :
                     state == FINAL ? OUT : (bus.out_ready ? ACCUM : OUT);
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= ACCUM;
         acc           <= '0;
         cnt           <= '0;
         bias_q        <= '0;
         err_q         <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_sat   <= 1'b0;
         bus.len_err   <= 1'b0;
      end else begin
         state <= state_nx;
         if (take) begin
            acc <= acc + prod;
            cnt <= at_last ? '0 : cnt + 1'b1;
            if (cnt == '0) bias_q <= bus.bias;
            if (bus.in_last != at_last) err_q <= 1'b1;
         end
         if (state == FINAL) begin
            bus.out_data  <= hi ? SMAX[DATA_W-1:0] : lo ? SMIN[DATA_W-1:0] : r[DATA_W-1:0];
            bus.out_sat   <= hi || lo;
            bus.len_err   <= err_q;
            bus.out_valid <= 1'b1;
         end
         if (state == OUT && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            acc           <= '0;
            cnt           <= '0;
            err_q         <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_neuron_mac_accumulator.sv
// tb_neuron_mac_accumulator: directed and random vectors against an integer dot-product model.
module tb_neuron_mac_accumulator;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   neuron_mac_accumulator_if #(.DATA_W(16)) m ();
   neuron_mac_accumulator_if #(.DATA_W(16)) m2 ();
   neuron_mac_accumulator #(.VEC_LEN(4)) dut (.clk(clk), .rst_n(rst_n), .bus(m.slave));
   neuron_mac_accumulator #(.VEC_LEN(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(m2.slave));
   int total = 0, passed = 0, failed = 0;
   logic signed [15:0] va [4];
   logic signed [15:0] vw [4];
   logic signed [15:0] vb;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask
   // Plain integer arithmetic: exact sum, floor division by 2^12, clip to int16.
   function automatic void model(input int n, output logic [15:0] d, output logic sat);
      longint a = longint'(vb) * 4096;
      for (int i = 0; i < n; i++) a += longint'(va[i]) * longint'(vw[i]);
`ifdef NEURON_MAC_ROUND_EN
      a += 2048;
`endif
      a = a >>> 12;
      sat = a > 32767 || a < -32768;
      d = a > 32767 ? 16'h7fff : a < -32768 ? 16'h8000 : 16'(a);
   endfunction
   task automatic send_beats(input int n, input int last_at);
      for (int i = 0; i < n; i++) begin
         int k;
         repeat ($urandom_range(0, 1)) begin
            m.in_valid = 1'b0;
            @(posedge clk); #1;
         end
         m.in_valid = 1'b1;
         m.in_data = va[i];
         m.in_weight = vw[i];
         m.in_last = i == last_at;
         for (k = 0; k < 40; k++) begin
            logic rdy;
            rdy = m.in_ready;
            @(posedge clk); #1;
            if (rdy) break;
         end
         chk("beat_accept", k < 40, 1);
         m.bias = 16'($urandom);
      end
      m.in_valid = 1'b0;
      m.in_last = 1'b0;
   endtask
   task automatic run_vec(input string tag, input int last_at, input int hold,
                          input logic use_k, input logic [15:0] k, input logic k_sat);
      logic [15:0] ed;
      logic es;
      model(4, ed, es);
      m.bias = vb;
      send_beats(4, last_at);
      chk({tag, "_lat1"}, m.out_valid, 0);
      @(posedge clk); #1;
      chk({tag, "_lat2"}, m.out_valid, 1);
      chk({tag, "_data"}, m.out_data, ed);
      chk({tag, "_sat"}, m.out_sat, es);
      chk({tag, "_len_err"}, m.len_err, last_at != 3);
      if (use_k) begin
         chk({tag, "_data_k"}, m.out_data, k);
         chk({tag, "_sat_k"}, m.out_sat, k_sat);
      end
      if (hold > 0) begin
         m.out_ready = 1'b0;
         m.in_valid = 1'b1;
         @(posedge clk); #1;
         for (int h = 0; h < hold; h++) begin
            chk({tag, "_hold_valid"}, m.out_valid, 1);
            chk({tag, "_hold_data"}, m.out_data, ed);
            chk({tag, "_hold_in_ready"}, m.in_ready, 0);
            if (h < hold - 1) begin
               @(posedge clk); #1;
            end
         end
         m.in_valid = 1'b0;
         m.out_ready = 1'b1;
      end
      @(posedge clk); #1;
      chk({tag, "_released"}, m.out_valid, 0);
      chk({tag, "_in_ready_again"}, m.in_ready, 1);
   endtask
   task automatic run2(input string tag, input logic [15:0] a0, input logic [15:0] w0,
                       input logic [15:0] k);
      chk({tag, "_ready"}, m2.in_ready, 1);
      m2.in_valid = 1'b1;
      m2.in_data = a0;
      m2.in_weight = w0;
      m2.in_last = 1'b0;
      @(posedge clk); #1;
      m2.in_data = '0;
      m2.in_weight = '0;
      m2.in_last = 1'b1;
      @(posedge clk); #1;
      m2.in_valid = 1'b0;
      m2.in_last = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_valid"}, m2.out_valid, 1);
      chk({tag, "_data"}, m2.out_data, k);
      @(posedge clk); #1;
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end
   initial begin
      {m.in_valid, m.in_data, m.in_weight, m.in_last, m.bias} = '0;
      {m2.in_valid, m2.in_data, m2.in_weight, m2.in_last, m2.bias} = '0;
      m.out_ready = 1'b1;
      m2.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", m.out_valid, 0);
      chk("rst_out_data", m.out_data, 0);
      chk("rst_out_sat", m.out_sat, 0);
      chk("rst_len_err", m.len_err, 0);
      chk("rst_in_ready", m.in_ready, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin va[i] = 16'h1000; vw[i] = 16'h1000; end
      vb = 16'h0000;
      run_vec("nominal", 3, 0, 1'b1, 16'h4000, 1'b0);
      for (int i = 0; i < 4; i++) begin va[i] = 16'h0800; vw[i] = 16'h1000; end
      vb = 16'shF000;
      run_vec("bias", 3, 0, 1'b1, 16'h1000, 1'b0);
      for (int i = 0; i < 4; i++) begin va[i] = 16'h7FFF; vw[i] = 16'h7FFF; end
      vb = 16'h0000;
      run_vec("sat_pos", 3, 5, 1'b1, 16'h7FFF, 1'b1);
      for (int i = 0; i < 4; i++) begin va[i] = 16'sh8000; vw[i] = 16'h7FFF; end
      run_vec("sat_neg", 3, 0, 1'b1, 16'h8000, 1'b1);
      for (int i = 0; i < 4; i++) begin va[i] = 16'h0400; vw[i] = 16'h2000; end
      vb = 16'h0100;
      run_vec("early_last", 1, 0, 1'b0, 16'h0, 1'b0);
      run_vec("framed", 3, 0, 1'b0, 16'h0, 1'b0);
      send_beats(2, -1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("midrst_out_valid", m.out_valid, 0);
      chk("midrst_out_data", m.out_data, 0);
      chk("midrst_out_sat", m.out_sat, 0);
      chk("midrst_len_err", m.len_err, 0);
      chk("midrst_in_ready", m.in_ready, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin va[i] = 16'h1000; vw[i] = 16'h1000; end
      vb = 16'h0000;
      run_vec("after_rst", 3, 0, 1'b1, 16'h4000, 1'b0);
      for (int t = 0; t < 24; t++) begin
         for (int i = 0; i < 4; i++) begin
            va[i] = (t % 3 == 0) ? 16'($urandom) : 16'($signed(12'($urandom)));
            vw[i] = (t % 3 == 0) ? 16'($urandom) : 16'($signed(14'($urandom)));
         end
         vb = 16'($urandom);
         run_vec("random", ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2)) : 3,
                 int'($urandom_range(0, 3)), 1'b0, 16'h0, 1'b0);
      end
`ifdef NEURON_MAC_ROUND_EN
      run2("round_pos", 16'h0001, 16'h0800, 16'h0001);
      run2("round_neg", 16'hFFFF, 16'h0800, 16'h0000);
`else
      run2("round_pos", 16'h0001, 16'h0800, 16'h0000);
      run2("round_neg", 16'hFFFF, 16'h0800, 16'hFFFF);
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
